// File: rtl/signed_step_counter_if.sv
// rtl/signed_step_counter_if.sv - control/data bundle for signed_step_counter
// The master drives load/count controls and operands; the slave returns the registered count and flags.
interface signed_step_counter_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             load;
   logic             up;
   logic             dn;
   logic [WIDTH-1:0] q;
   logic             ovf;
   logic             ovf_sticky;

   modport master (
      output a, b, load, up, dn,
      input  q, ovf, ovf_sticky
   );

   modport slave (
      input  a, b, load, up, dn,
      output q, ovf, ovf_sticky
   );
endinterface

// File: rtl/signed_step_counter.sv
// rtl/signed_step_counter.sv - signed up/down counter with programmable step, load and overflow flags
// Build option SIGNED_STEP_COUNTER_SAT_EN: saturate on overflow instead of wrapping modulo 2^WIDTH.
module signed_step_counter #(
   parameter int WIDTH = 8
) (
   input logic                  clk,
   input logic                  rst,
   signed_step_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] q_reg;
   logic             ovf_reg;
   logic             sticky_reg;

   logic             count_en;
   logic [WIDTH:0]   q_ext;
   logic [WIDTH:0]   b_ext;
   logic [WIDTH:0]   r;
   logic             overflow;
   logic [WIDTH-1:0] step_val;

   logic [WIDTH-1:0] q_next;
   logic             ovf_next;
   logic             sticky_next;

   // One extra bit holds the exact sum/difference; overflow shows as disagreement of the top two bits.
   always_comb begin
      count_en = bus.up ^ bus.dn;
      q_ext    = {q_reg[WIDTH-1], q_reg};
      b_ext    = {bus.b[WIDTH-1], bus.b};
      r        = bus.up ? (q_ext + b_ext) : (q_ext - b_ext);
      overflow = r[WIDTH] ^ r[WIDTH-1];
`ifdef SIGNED_STEP_COUNTER_SAT_EN
      if (overflow) begin
         step_val = r[WIDTH] ? MIN_VAL : MAX_VAL;
      end else begin
         step_val = r[WIDTH-1:0];
      end
`else
      step_val = r[WIDTH-1:0];
`endif
   end

   always_comb begin
      q_next      = q_reg;
      ovf_next    = 1'b0;
      sticky_next = sticky_reg;
      if (bus.load) begin
         q_next      = bus.a;
         sticky_next = 1'b0;
      end else if (count_en) begin
         q_next      = step_val;
         ovf_next    = overflow;
         sticky_next = sticky_reg | overflow;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_reg      <= '0;
         ovf_reg    <= 1'b0;
         sticky_reg <= 1'b0;
      end else begin
         q_reg      <= q_next;
         ovf_reg    <= ovf_next;
         sticky_reg <= sticky_next;
      end
   end

   assign bus.q          = q_reg;
   assign bus.ovf        = ovf_reg;
   assign bus.ovf_sticky = sticky_reg;
endmodule

// File: tb/tb_signed_step_counter.sv
// tb/tb_signed_step_counter.sv - self-checking bench for signed_step_counter
// Honours SIGNED_STEP_COUNTER_SAT_EN to select the saturating expectations.
module tb_signed_step_counter;
   localparam int W    = 8;
   localparam int MAXV = (1 << (W - 1)) - 1;
   localparam int MINV = -(1 << (W - 1));
`ifdef SIGNED_STEP_COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   signed_step_counter_if #(.WIDTH(W)) bus ();

   signed_step_counter #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int qs();
      logic signed [W-1:0] v;
      v = bus.q;
      return int'(v);
   endfunction

   function automatic int sx(input logic [W-1:0] v);
      logic signed [W-1:0] s;
      s = v;
      return int'(s);
   endfunction

   // Reference: exact integer arithmetic, then wrap or clamp into the signed range.
   int mq, movf, mst, mvalid = 0;
   always @(posedge clk) begin
      int r;
      if (rst) begin
         mq = 0; movf = 0; mst = 0; mvalid = 1;
      end else if (bus.load) begin
         mq = sx(bus.a); movf = 0; mst = 0;
      end else if (bus.up != bus.dn) begin
         r = bus.up ? mq + sx(bus.b) : mq - sx(bus.b);
         if (r > MAXV || r < MINV) begin
            movf = 1; mst = 1;
            if (SAT) mq = (r > MAXV) ? MAXV : MINV;
            else     mq = (r > MAXV) ? r - (1 << W) : r + (1 << W);
         end else begin
            movf = 0; mq = r;
         end
      end else begin
         movf = 0;
      end
   end

   always @(negedge clk) begin
      if (mvalid != 0) begin
         chk("model_q", qs(), mq);
         chk("model_ovf", int'(bus.ovf), movf);
         chk("model_sticky", int'(bus.ovf_sticky), mst);
      end
   end

   task automatic step(input logic r_i, input logic l, input logic u, input logic d,
                       input int av, input int bv);
      logic [31:0] a32, b32;
      a32 = av; b32 = bv;
      rst = r_i; bus.load = l; bus.up = u; bus.dn = d;
      bus.a = a32[W-1:0]; bus.b = b32[W-1:0];
      @(posedge clk);
      #1;
   endtask

   int exp_up[7] = '{-19, -38, -57, -76, -95, -114, 0};
   int exp_dn[5] = '{-30, -60, -90, -120, 0};

   initial begin
      bus.load = 1'b0; bus.up = 1'b1; bus.dn = 1'b0; bus.a = 8'h55; bus.b = 8'h00;
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 1, 0, 'h55, 0);
         chk("rst_q", qs(), 0);
         chk("rst_ovf", int'(bus.ovf), 0);
         chk("rst_sticky", int'(bus.ovf_sticky), 0);
      end

      exp_up[6] = SAT ? -128 : 123;
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         step(0, 0, 1, 0, 0, -19);
         chk("up19_q", qs(), exp_up[i]);
         chk("up19_ovf", int'(bus.ovf), (i == 6) ? 1 : 0);
      end
      step(0, 0, 0, 0, 0, -19);
      chk("up19_sticky_hold", int'(bus.ovf_sticky), 1);
      chk("up19_ovf_drop", int'(bus.ovf), 0);

      exp_dn[4] = SAT ? -128 : 106;
      step(0, 1, 0, 0, 0, 0);
      chk("load_clears_sticky", int'(bus.ovf_sticky), 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 1, 0, 30);
         chk("dn30_q", qs(), exp_dn[i]);
         chk("dn30_ovf", int'(bus.ovf), (i == 4) ? 1 : 0);
      end

      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, -128);
      chk("dn_min_q", qs(), SAT ? 127 : -128);
      chk("dn_min_ovf", int'(bus.ovf), 1);

      step(0, 1, 0, 0, 5, 0);
      step(0, 0, 1, 1, 0, 9);
      step(0, 0, 1, 1, 0, 9);
      chk("both_hold_q", qs(), 5);
      chk("both_hold_ovf", int'(bus.ovf), 0);
      step(0, 1, 1, 0, -7, 3);
      chk("load_wins_q", qs(), -7);
      chk("load_wins_sticky", int'(bus.ovf_sticky), 0);
      step(0, 0, 1, 0, 0, 0);
      chk("zero_step_q", qs(), -7);
      chk("zero_step_ovf", int'(bus.ovf), 0);

      // Back-to-back overflows keep ovf high in saturate mode; wrap mode recovers.
      step(0, 1, 0, 0, 100, 0);
      step(0, 0, 1, 0, 0, 100);
      step(0, 0, 1, 0, 0, 100);
      step(0, 0, 0, 1, 0, 77);
      step(0, 0, 1, 0, 0, 127);

      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, -128);
      step(0, 0, 1, 0, 0, -128);
      chk("pre_rst_sticky", int'(bus.ovf_sticky), 1);
      step(1, 0, 1, 0, 0, -128);
      chk("mid_rst_q", qs(), 0);
      chk("mid_rst_ovf", int'(bus.ovf), 0);
      chk("mid_rst_sticky", int'(bus.ovf_sticky), 0);
      step(0, 0, 1, 0, 0, -128);
      chk("resume_q", qs(), -128);
      step(0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
